// File: rtl/skipring_mc.sv
// rtl/skipring_mc.sv - multi-channel pulse-skipping ring with frame-aligned pattern commit
module skipring_mc #(
  parameter int               LEN     = 16,
  parameter int               CH      = 4,
  parameter int               DIV_W   = 8,
  parameter logic [LEN-1:0]   defSEL  = LEN'(1),
  parameter logic [LEN-1:0]   defMASK = '0,
  localparam int              AW      = $clog2(CH + 1),
  localparam int              PW      = $clog2(LEN)
) (
  input  logic             iCLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIV,
  input  logic [CH-1:0]    E,
  input  logic [CH-1:0]    MODE,
  input  logic             WR,
  input  logic [AW-1:0]    WADDR,
  input  logic [LEN-1:0]   WDATA,
  output logic             oPEND,
  output logic             oWERR,
  output logic             oTICK,
  output logic [CH-1:0]    oEN,
  output logic             oB0,
  output logic [PW-1:0]    oPOS
);

  localparam logic [AW-1:0] RING_ADDR = AW'(CH);
  localparam logic [PW-1:0] LAST_POS  = PW'(LEN - 1);

  logic [DIV_W-1:0] cnt;
  logic [PW-1:0]    pos;
  logic [LEN-1:0]   ring;
  logic [LEN-1:0]   mask [CH];
  logic [AW-1:0]    sh_addr;
  logic [LEN-1:0]   sh_data;
  logic             tick;
  logic             boundary;
  logic             commit;
  logic             wr_bad;
  logic [CH-1:0]    skip;

  // '>=' rather than '==' so lowering DIV below the running count ticks at once instead of wrapping
  assign tick     = (cnt >= DIV);
  assign boundary = tick && (pos == LAST_POS);
  assign commit   = boundary && oPEND;
  assign wr_bad   = (WADDR > RING_ADDR);

  assign oB0  = ring[0];
  assign oPOS = pos;

  // per-channel skip decision from the mask bit at the pre-tick position
  always_comb begin
    skip = '0;
    for (int c = 0; c < CH; c++) begin
      skip[c] = E[c] & (MODE[c] ? ~mask[c][pos] : mask[c][pos]);
    end
  end

  // prescaler and frame position
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      pos <= '0;
    end else if (tick) begin
      cnt <= '0;
      pos <= (pos == LAST_POS) ? '0 : pos + PW'(1);
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // ring rotates right each tick; a committed ring write replaces the rotation outright
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      ring <= defSEL;
    end else if (commit && (sh_addr == RING_ADDR)) begin
      ring <= sh_data;
    end else if (tick) begin
      ring <= {ring[0], ring[LEN-1:1]};
    end
  end

  // channel masks take the shadow value only at a frame boundary
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      for (int c = 0; c < CH; c++) begin
        mask[c] <= defMASK;
      end
    end else if (commit) begin
      for (int c = 0; c < CH; c++) begin
        if (sh_addr == AW'(c)) begin
          mask[c] <= sh_data;
        end
      end
    end
  end

  // single-entry shadow: accept when empty, reject (sticky error) when busy or misaddressed
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      oPEND   <= 1'b0;
      oWERR   <= 1'b0;
      sh_addr <= '0;
      sh_data <= '0;
    end else begin
      if (commit) begin
        oPEND <= 1'b0;
      end
      if (WR) begin
        if (wr_bad || oPEND) begin
          oWERR <= 1'b1;
        end else begin
          sh_addr <= WADDR;
          sh_data <= WDATA;
          oPEND   <= 1'b1;
        end
      end
    end
  end

  // registered tick and per-channel enable pulses, one cycle after the tick
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      oTICK <= 1'b0;
      oEN   <= '0;
    end else begin
      oTICK <= tick;
      oEN   <= {CH{tick}} & ~skip;
    end
  end

endmodule
